// File: rtl/time_tag_merge_pkg.sv
// Shared frontend definitions: field widths, word layout and word builders
// for the merged event / time-tag stream.
package time_tag_merge_pkg;

  localparam int EV_W        = 45;
  localparam int STAMP_W     = 17;
  localparam int PERIOD_W    = 48;
  localparam int WORD_W      = 64;
  localparam int DROP_W      = 8;

  // Bit 63 tells tags from events; bit 62 is reserved (0) in event words.
  localparam int TYPE_BIT    = 63;
  localparam int SUBTYPE_BIT = 62;

  localparam int TAG_HDR_W   = 15;
  localparam logic [TAG_HDR_W-1:0] TAG_HDR = 15'h0;

  typedef enum logic {
    WT_EVENT = 1'b0,
    WT_TAG   = 1'b1
  } word_type_e;

  // Event word: {type, reserved, stamp, payload}.
  function automatic logic [WORD_W-1:0] make_event_word(
    input logic [STAMP_W-1:0] stamp,
    input logic [EV_W-1:0]    data
  );
    logic [WORD_W-1:0] w;
    w                   = '0;
    w[TYPE_BIT]         = WT_EVENT;
    w[SUBTYPE_BIT]      = 1'b0;
    w[EV_W +: STAMP_W]  = stamp;
    w[EV_W-1:0]         = data;
    return w;
  endfunction

  // Time tag word: {type, header, latched period}.
  function automatic logic [WORD_W-1:0] make_tag_word(
    input logic [PERIOD_W-1:0] per
  );
    logic [WORD_W-1:0] w;
    w                          = '0;
    w[TYPE_BIT]                = WT_TAG;
    w[PERIOD_W +: TAG_HDR_W]   = TAG_HDR;
    w[PERIOD_W-1:0]            = per;
    return w;
  endfunction

endpackage

// File: rtl/time_tag_merge_stream_reg.sv
// Output stage: one-word valid/ready register slice. A tag load wins over an
// event load; the word is held stable while the consumer stalls.
module time_tag_merge_stream_reg
  import time_tag_merge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_tag_i,
  input  logic              load_ev_i,
  input  logic [WORD_W-1:0] tag_word_i,
  input  logic [WORD_W-1:0] ev_word_i,
  input  logic              out_ready_i,
  output logic              free_o,
  output logic              out_valid_o,
  output logic [WORD_W-1:0] out_data_o
);

  logic              valid_q;
  logic [WORD_W-1:0] data_q;

  // The slot can take a new word when empty or being drained this cycle.
  assign free_o      = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Load mux with tag priority; go idle after a transfer with nothing to load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (free_o) begin
      if (load_tag_i) begin
        valid_q <= 1'b1;
        data_q  <= tag_word_i;
      end else if (load_ev_i) begin
        valid_q <= 1'b1;
        data_q  <= ev_word_i;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/time_tag_merge.sv
// Merges timestamped events with per-period time tags into one 64-bit stream.
// A single tag slot absorbs period_done pulses; pulses arriving while a tag is
// still waiting are counted as drops. Events are blocked while a tag waits so
// that the tag is emitted ahead of every event accepted after its pulse.
module time_tag_merge
  import time_tag_merge_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [STAMP_W-1:0]  counter,
  input  logic [PERIOD_W-1:0] period,
  input  logic                period_done,
  input  logic                ev_valid,
  input  logic [EV_W-1:0]     ev_data,
  output logic                ev_ready,
  output logic                out_valid,
  output logic [WORD_W-1:0]   out_data,
  input  logic                out_ready,
  output logic [DROP_W-1:0]   drop_count
);

  logic                tag_pending_q, tag_pending_d;
  logic [PERIOD_W-1:0] tag_q, tag_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                free;
  logic                ev_fire;
  logic                load_tag;

  // Events wait while a tag is pending or being captured this cycle.
  assign ev_ready   = !rst && free && !tag_pending_q && !period_done;
  assign ev_fire    = ev_valid && ev_ready;
  assign load_tag   = tag_pending_q && free;
  assign drop_count = drop_q;

  // Next state of the tag slot and the saturating drop counter.
  always_comb begin
    tag_pending_d = tag_pending_q;
    tag_d         = tag_q;
    drop_d        = drop_q;
    if (load_tag) begin
      tag_pending_d = 1'b0;
    end
    if (period_done) begin
      if (!tag_pending_q) begin
        tag_d         = period;
        tag_pending_d = 1'b1;
      end else if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  // Tag slot and drop counter registers; reset clears any waiting tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_pending_q <= 1'b0;
      tag_q         <= '0;
      drop_q        <= '0;
    end else begin
      tag_pending_q <= tag_pending_d;
      tag_q         <= tag_d;
      drop_q        <= drop_d;
    end
  end

  time_tag_merge_stream_reg stream_reg (
    .clk         (clk),
    .rst         (rst),
    .load_tag_i  (load_tag),
    .load_ev_i   (ev_fire),
    .tag_word_i  (make_tag_word(tag_q)),
    .ev_word_i   (make_event_word(counter, ev_data)),
    .out_ready_i (out_ready),
    .free_o      (free),
    .out_valid_o (out_valid),
    .out_data_o  (out_data)
  );

endmodule

// File: tb/tb_time_tag_merge.sv
// Scoreboard bench for time_tag_merge: accepted events and period pulses push
// expected words in stream order; a monitor pops and compares on every transfer.
module tb_time_tag_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] counter;
  logic [47:0] period;
  logic        period_done;
  logic        ev_valid;
  logic [44:0] ev_data;
  logic        ev_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic [7:0]  drop_count;

  int checks = 0;
  int passes = 0;

  logic [63:0] exp_q[$];
  int          drop_exp = 0;
  int          ev_in = 0, ev_out = 0, tags_in = 0, tags_out = 0;
  logic [47:0] last_tag = '0;
  bit          order_on = 1'b0;

  time_tag_merge dut (
    .clk         (clk),
    .rst         (rst),
    .counter     (counter),
    .period      (period),
    .period_done (period_done),
    .ev_valid    (ev_valid),
    .ev_data     (ev_data),
    .ev_ready    (ev_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the stream is the acceptance order of events and tags.
  // A new pulse is dropped while an earlier tag is still inside the DUT and not
  // yet on the output, i.e. the queue holds more than the word being held.
  initial begin
    int held;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        drop_exp = 0;
      end else begin
        if (ev_valid && ev_ready) begin
          exp_q.push_back({2'b00, counter, ev_data});
          ev_in++;
        end
        if (period_done) begin
          held = (out_valid && !out_ready) ? 1 : 0;
          if (exp_q.size() > held) begin
            if (drop_exp < 255) drop_exp++;
          end else begin
            exp_q.push_back({1'b1, 15'h0, period});
            tags_in++;
          end
        end
      end
    end
  end

  // Monitor: compare every transferred word with the scoreboard head.
  initial begin
    logic [63:0] exp_w;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got %h required none", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          chk("stream_word", out_data, exp_w);
          if (out_data[63]) begin
            tags_out++;
            if (order_on) chk("tag_ascending", 64'(out_data[47:0] > last_tag), 64'd1);
            last_tag = out_data[47:0];
          end else begin
            ev_out++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vrec[14];
    int first, last, gaps;
    logic [63:0] hold_word;

    rst = 1'b1; counter = '0; period = '0; period_done = 1'b0;
    ev_valid = 1'b1; ev_data = '0; out_ready = 1'b1;
    step(); step(); step();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_ev_ready", 64'(ev_ready), 64'd0);
    rst = 1'b0; ev_valid = 1'b0;
    step();

    // Single event: latency 1, stamp from counter.
    period = 48'h5; counter = 17'd100; ev_data = 45'h1; ev_valid = 1'b1;
    #1 chk("ev_ready_idle", 64'(ev_ready), 64'd1);
    step();
    ev_valid = 1'b0;
    #1;
    chk("ev_latency_valid", 64'(out_valid), 64'd1);
    chk("ev_word", out_data, {2'b00, 17'd100, 45'h1});
    step();
    #1 chk("idle_after_xfer", 64'(out_valid), 64'd0);

    // Tag appears two cycles after its pulse; events blocked at T and T+1.
    period = 48'hABCD; period_done = 1'b1; ev_valid = 1'b1;
    #1 chk("ev_ready_T", 64'(ev_ready), 64'd0);
    step();
    period_done = 1'b0;
    #1;
    chk("ev_ready_T1", 64'(ev_ready), 64'd0);
    chk("tag_not_yet_T1", 64'(out_valid), 64'd0);
    ev_valid = 1'b0;
    step();
    #1;
    chk("tag_valid_T2", 64'(out_valid), 64'd1);
    chk("tag_word_T2", out_data, {1'b1, 15'h0, 48'hABCD});
    step(); step();

    // Continuous events around a pulse: order via scoreboard, at most 1 gap.
    ev_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      counter = 17'(c * 3 + 7);
      ev_data = 45'({$urandom(), $urandom()});
      period_done = (c == 6);
      if (c == 6) period = 48'h1_0000;
      step();
      #1 vrec[c] = out_valid ? 1 : 0;
    end
    ev_valid = 1'b0; period_done = 1'b0;
    first = -1; last = -1; gaps = 0;
    for (int c = 0; c < 14; c++) if (vrec[c] == 1) begin if (first < 0) first = c; last = c; end
    for (int c = 0; c < 14; c++) if (c > first && c < last && vrec[c] == 0) gaps++;
    chk("gap_le_1", 64'(gaps <= 1), 64'd1);
    step(); step(); step();

    // Backpressure across 3 pulses: first tag kept, two dropped, word held.
    out_ready = 1'b0;
    counter = 17'd555; ev_data = 45'h123; ev_valid = 1'b1;
    step();
    ev_valid = 1'b0;
    hold_word = {2'b00, 17'd555, 45'h123};
    for (int k = 0; k < 3; k++) begin
      period = 48'h2_0000 + 48'(k); period_done = 1'b1;
      step();
      period_done = 1'b0;
      step(); step();
    end
    #1;
    chk("drop_count_3pulses", 64'(drop_count), 64'd2);
    chk("held_valid", 64'(out_valid), 64'd1);
    chk("held_data", out_data, hold_word);
    out_ready = 1'b1;
    step();
    #1 chk("first_tag_after_release", out_data, {1'b1, 15'h0, 48'h2_0000});
    step(); step(); step();

    // 300 drops saturate; reset mid-transfer discards everything.
    out_ready = 1'b0;
    for (int k = 0; k < 300; k++) begin
      period = period + 48'd1; period_done = 1'b1;
      step();
    end
    period_done = 1'b0;
    #1;
    chk("drop_saturate", 64'(drop_count), 64'd255);
    chk("drop_model", 64'(drop_count), 64'(drop_exp));
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    step();
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_data", out_data, 64'd0);
    chk("rst_mid_drop", 64'(drop_count), 64'd0);
    chk("rst_mid_ev_ready", 64'(ev_ready), 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      #1 chk("no_stale_word", 64'(out_valid), 64'd0);
    end

    // Random traffic and backpressure over 10 periods.
    ev_in = 0; ev_out = 0; tags_in = 0; tags_out = 0;
    order_on = 1'b1; last_tag = '0;
    period = 48'h3_0000;
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < 40; c++) begin
        counter = 17'(c * 2 + p);
        out_ready = ($urandom_range(0, 3) != 0);
        ev_valid = $urandom_range(0, 1) == 1;
        ev_data = 45'({$urandom(), $urandom()});
        period_done = (c == 20);
        if (c == 20) period = period + 48'd1;
        step();
      end
    end
    period_done = 1'b0; ev_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("event_count", 64'(ev_out), 64'(ev_in));
    chk("tag_count", 64'(tags_out), 64'(tags_in));
    chk("tags_emitted", 64'(tags_out + drop_exp), 64'd10);
    chk("drop_random", 64'(drop_count), 64'(drop_exp));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/time_tag_merge.md
TIME_TAG_MERGE -- requirements
Module: time_tag_merge

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on posedge clk.
REQ-002 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have port counter, input, 17, fine-time count within the current 1 ms period, from the timer.
REQ-004 SHALL have port period, input, 48, coarse period count, from the timer.
REQ-005 SHALL have port period_done, input, 1, one-cycle pulse per 1 ms period, from the timer.
REQ-006 SHALL have port ev_valid, input, 1, event word valid.
REQ-007 SHALL have port ev_data, input, 45, event payload.
REQ-008 SHALL have port ev_ready, output, 1, event accepted when ev_valid & ev_ready.
REQ-009 SHALL have port out_valid, output, 1, merged stream word valid.
REQ-010 SHALL have port out_data, output, 64, merged stream word.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts word when out_valid & out_ready.
REQ-012 SHALL have port drop_count, output, 8, number of time tags discarded, saturating.

Function
REQ-013 SHALL format event words as {1'b0, 1'b0, stamp[16:0], ev_data[44:0]}, where stamp is counter sampled in the acceptance cycle.
REQ-014 SHALL format time tags as {1'b1, 15'h0, period_latched[47:0]}, where period_latched is period sampled in the cycle period_done=1.
REQ-015 SHALL hold one tag register and one tag_pending flag; period_done=1 with tag_pending=0 loads the tag register and sets tag_pending on the next cycle.
REQ-016 SHALL, on period_done=1 with tag_pending=1, keep the pending tag unchanged, discard the new tag, and increment drop_count, saturating at 255.
REQ-017 SHALL define free = !out_valid | out_ready.
REQ-018 SHALL drive ev_ready = free & !tag_pending & !period_done, combinationally.
REQ-019 SHALL load the pending tag into the output register whenever tag_pending & free, clearing tag_pending in the same edge; a tag SHALL have priority over events.
REQ-020 SHALL make an accepted event appear on out_valid/out_data on the next cycle; latency is 1 clock.
REQ-021 SHALL present a tag on out_valid at earliest 2 cycles after its period_done pulse.
REQ-022 SHALL hold out_data stable and out_valid high while out_valid & !out_ready.
REQ-023 SHALL deassert out_valid after a transfer when no tag is pending and no event is accepted in that cycle.
REQ-024 SHALL emit every tag before any event accepted on or after its period_done cycle; events accepted before that cycle SHALL precede the tag.
REQ-025 SHALL sustain 1 word per clock while out_ready=1.
REQ-026 SHALL not stall period_done handling under out_ready=0; only drops per REQ-016 occur.

Reset
REQ-027 SHALL, with rst=1, drive out_valid=0, out_data=0, tag_pending=0, tag register=0, drop_count=0, and ev_ready=0.
REQ-028 SHALL, on rst mid-transfer, discard any pending tag and output word without emitting it; the first valid output after rst SHALL be newly generated.
REQ-029 SHALL have rst take priority over period_done and over all handshakes in the same cycle.

Structure
REQ-030 SHALL take word-type bit positions, the tag header constant 15'h0, and the 45/17/48 field widths from the shared frontend package.
REQ-031 SHALL implement the output stage as one sub-module, stream_reg: a 64-bit valid/ready register slice with a load mux for tag versus event.

Verification
REQ-032 SHALL cover: out_ready=1, period=48'h5, event accepted at counter=17'd100 with ev_data=45'h1 -> next cycle out_data={2'b00,17'd100,45'h1}.
REQ-033 SHALL cover: period_done at cycle T with period=48'hABCD, out_ready=1 -> tag {1'b1,15'h0,48'hABCD} at T+2; ev_ready=0 at T and T+1.
REQ-034 SHALL cover: ev_valid held high and period_done pulsed at T -> all events accepted before T precede the tag, all others follow it, with no gaps beyond 1 cycle.
REQ-035 SHALL cover: out_ready=0 across 3 period_done pulses -> first tag retained, drop_count=2, out_data stable; release -> first tag emitted.
REQ-036 SHALL cover: 300 drops -> drop_count=255; rst asserted with out_valid=1 and tag_pending=1 -> all outputs 0 on the next cycle and no stale word emitted.
REQ-037 SHALL cover: random out_ready backpressure over 10 periods -> every tag emitted once in ascending period order, and the event count out equals the event count in.
